// File: rtl/ha1588_pkg.sv
// Shared PTP time definitions: time widths, nanosecond wrap, target FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ha1588_pkg;

    localparam int SEC_W = 48;
    localparam int NS_W  = 32;

    // Nanoseconds field rolls over at one second.
    localparam logic [NS_W-1:0] NS_PER_SEC = 32'd1_000_000_000;

    // Seconds in the upper bits, so the packed struct compares as one
    // 80-bit unsigned timestamp.
    typedef struct packed {
        logic [SEC_W-1:0] sec;
        logic [NS_W-1:0]  ns;
    } ptp_time_t;

    typedef enum logic [1:0] {
        TGT_IDLE  = 2'd0,
        TGT_ARMED = 2'd1,
        TGT_ADV   = 2'd2
    } tgt_state_t;

    // True when a nanoseconds value (or a nanosecond increment) is a
    // legal sub-second quantity.
    function automatic logic ns_in_range(input logic [NS_W-1:0] ns);
        return ns < NS_PER_SEC;
    endfunction

endpackage

// File: rtl/ptp_evt_gen_if.sv
// Register-block control/status bundle for the timed-event generator.
// Latency: n/a (wires only).
// Backpressure: none; strobes are single-cycle, status is level or pulse.
//
// Signals:
//   tgt_ld        : one-cycle strobe, load target and arm
//   tgt_sec/ns    : target time
//   tgt_period_ns : re-arm increment, 0 = one-shot
//   tgt_cancel    : one-cycle strobe, disarm (wins over tgt_ld)
//   armed         : target armed
//   ld_err        : one-cycle pulse, tgt_ld rejected
//   missed        : sticky, a periodic re-arm landed in the past
interface ptp_evt_gen_if;
    import ha1588_pkg::*;

    logic             tgt_ld;
    logic [SEC_W-1:0] tgt_sec;
    logic [NS_W-1:0]  tgt_ns;
    logic [NS_W-1:0]  tgt_period_ns;
    logic             tgt_cancel;
    logic             armed;
    logic             ld_err;
    logic             missed;

    // Register block side.
    modport master (
        output tgt_ld, tgt_sec, tgt_ns, tgt_period_ns, tgt_cancel,
        input  armed, ld_err, missed
    );

    // Event generator side.
    modport slave (
        input  tgt_ld, tgt_sec, tgt_ns, tgt_period_ns, tgt_cancel,
        output armed, ld_err, missed
    );

endinterface

// File: rtl/ptp_time_add.sv
// Combinational PTP time adder: {sec,ns} + ns with wrap at one second.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   sec_i/ns_i : base time, ns_i < NS_PER_SEC
//   add_ns_i   : increment, < NS_PER_SEC
//   sec_o/ns_o : sum; seconds wrap modulo 2^SEC_W
module ptp_time_add
    import ha1588_pkg::*;
(
    input  logic [SEC_W-1:0] sec_i,
    input  logic [NS_W-1:0]  ns_i,
    input  logic [NS_W-1:0]  add_ns_i,
    output logic [SEC_W-1:0] sec_o,
    output logic [NS_W-1:0]  ns_o
);

    // One extra bit so the raw sum can never alias, whatever the inputs.
    logic [NS_W:0] ns_sum;
    logic [NS_W:0] ns_wrap;

    assign ns_sum  = {1'b0, ns_i} + {1'b0, add_ns_i};
    assign ns_wrap = ns_sum - {1'b0, NS_PER_SEC};

    // With both operands below one second, at most one carry is possible.
    always_comb begin
        sec_o = sec_i;
        ns_o  = ns_sum[NS_W-1:0];
        if (ns_sum >= {1'b0, NS_PER_SEC}) begin
            ns_o  = ns_wrap[NS_W-1:0];
            sec_o = sec_i + {{(SEC_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/ptp_evt_gen.sv
// PTP timed outputs: PPS pulse on each seconds change, plus a one-shot/periodic target-time event.
// Latency: pps_out and evt_out both assert 2 clk edges after the triggering time value is driven.
// Backpressure: none; control strobes are accepted every cycle, outputs cannot be stalled.
//
// Ports:
//   clk, rst       : RTC clock, synchronous active-high reset
//   time_ptp_sec/ns: live RTC time, registered before use
//   pps_width      : PPS high time in clocks (0 behaves as 1)
//   ctl            : register-block control/status (ptp_evt_gen_if.slave)
//   pps_out        : PPS pulse
//   evt_out        : one-cycle target event pulse
module ptp_evt_gen
    import ha1588_pkg::*;
#(
    parameter int PW_WIDTH = 16
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NS_W-1:0]     time_ptp_ns,
    input  logic [SEC_W-1:0]    time_ptp_sec,
    input  logic [PW_WIDTH-1:0] pps_width,
    ptp_evt_gen_if.slave        ctl,
    output logic                pps_out,
    output logic                evt_out
);

    localparam logic [PW_WIDTH-1:0] PW_ONE = {{(PW_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Input stage: every decision below works on the registered time.
    // ------------------------------------------------------------------
    ptp_time_t time_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            time_q <= '0;
        end else begin
            time_q <= {time_ptp_sec, time_ptp_ns};
        end
    end

    // ------------------------------------------------------------------
    // PPS generation
    // ------------------------------------------------------------------
    // time_vld_q marks that time_q holds a real sample; seen_first_q marks
    // that sec_prev_q does too. Comparing only once both hold real
    // samples keeps the first post-reset time value from looking like a
    // seconds change.
    logic                time_vld_q;
    logic                seen_first_q;
    logic [SEC_W-1:0]    sec_prev_q;
    logic [PW_WIDTH-1:0] pps_cnt_q;
    logic [PW_WIDTH-1:0] pps_cnt_d;
    logic                rollover;

    // Any change counts, including a backward jump after an RTC load.
    assign rollover = seen_first_q && (time_q.sec != sec_prev_q);

    always_comb begin
        pps_cnt_d = pps_cnt_q;
        if (rollover) begin
            // Restarts the count even if a pulse is already running.
            pps_cnt_d = (pps_width == '0) ? PW_ONE : pps_width;
        end else if (pps_cnt_q != '0) begin
            pps_cnt_d = pps_cnt_q - PW_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_vld_q   <= 1'b0;
            seen_first_q <= 1'b0;
            sec_prev_q   <= '0;
            pps_cnt_q    <= '0;
        end else begin
            time_vld_q   <= 1'b1;
            seen_first_q <= time_vld_q;
            sec_prev_q   <= time_q.sec;
            pps_cnt_q    <= pps_cnt_d;
        end
    end

    // High for exactly the loaded number of cycles.
    assign pps_out = (pps_cnt_q != '0);

    // ------------------------------------------------------------------
    // Target-time event FSM
    // ------------------------------------------------------------------
    tgt_state_t      state_q, state_d;
    ptp_time_t       tgt_q, tgt_d;
    logic [NS_W-1:0] per_q, per_d;
    logic            missed_q, missed_d;
    logic            evt_q, evt_d;
    logic            ld_err_q, ld_err_d;

    logic            ld_ok;
    logic            hit;
    ptp_time_t       adv_time;

    assign ld_ok = ns_in_range(ctl.tgt_ns) && ns_in_range(ctl.tgt_period_ns);
    assign hit   = (time_q >= tgt_q);

    // Next periodic target; only consumed in TGT_ADV.
    ptp_time_add u_adv (
        .sec_i    (tgt_q.sec),
        .ns_i     (tgt_q.ns),
        .add_ns_i (per_q),
        .sec_o    (adv_time.sec),
        .ns_o     (adv_time.ns)
    );

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        per_d    = per_q;
        missed_d = missed_q;
        evt_d    = 1'b0;
        // A rejected load never disturbs the FSM; a cancel hides it.
        ld_err_d = ctl.tgt_ld && !ctl.tgt_cancel && !ld_ok;

        if (ctl.tgt_cancel) begin
            state_d = TGT_IDLE;
        end else if (ctl.tgt_ld && ld_ok) begin
            // Retarget from any state; a pending advance is dropped.
            tgt_d    = {ctl.tgt_sec, ctl.tgt_ns};
            per_d    = ctl.tgt_period_ns;
            missed_d = 1'b0;
            state_d  = TGT_ARMED;
        end else begin
            case (state_q)
                TGT_ARMED: begin
                    if (hit) begin
                        evt_d   = 1'b1;
                        state_d = (per_q == '0) ? TGT_IDLE : TGT_ADV;
                    end
                end
                TGT_ADV: begin
                    // No compare this cycle, so each advance yields at most
                    // one event. A target that is already due flags missed
                    // and still fires on the next ARMED compare.
                    tgt_d   = adv_time;
                    state_d = TGT_ARMED;
                    if (adv_time <= time_q) begin
                        missed_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= TGT_IDLE;
            tgt_q    <= '0;
            per_q    <= '0;
            missed_q <= 1'b0;
            evt_q    <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            per_q    <= per_d;
            missed_q <= missed_d;
            evt_q    <= evt_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign evt_out    = evt_q;
    assign ctl.armed  = (state_q != TGT_IDLE);
    assign ctl.ld_err = ld_err_q;
    assign ctl.missed = missed_q;

endmodule

// File: tb/tb_ptp_evt_gen.sv
// Directed self-checking bench for ptp_evt_gen.
// Latency: n/a.
// Backpressure: n/a.
module tb_ptp_evt_gen;
    import ha1588_pkg::*;

    logic             clk;
    logic             rst;
    logic [NS_W-1:0]  time_ptp_ns;
    logic [SEC_W-1:0] time_ptp_sec;
    logic [15:0]      pps_width;
    logic             pps_out;
    logic             evt_out;
    logic [NS_W-1:0]  inc;

    int n_chk;
    int n_fail;

    ptp_evt_gen_if ctl();

    ptp_evt_gen #(.PW_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .time_ptp_ns  (time_ptp_ns),
        .time_ptp_sec (time_ptp_sec),
        .pps_width    (pps_width),
        .ctl          (ctl),
        .pps_out      (pps_out),
        .evt_out      (evt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; afterwards the RTC model advances by inc ns.
    task automatic clk_step();
        @(posedge clk);
        #1;
        time_ptp_ns = time_ptp_ns + inc;
        if (time_ptp_ns >= 32'd1000000000) begin
            time_ptp_ns  = time_ptp_ns - 32'd1000000000;
            time_ptp_sec = time_ptp_sec + 48'd1;
        end
    endtask

    task automatic drive_ld(input logic [47:0] s, input logic [31:0] ns, input logic [31:0] per);
        ctl.tgt_sec       = s;
        ctl.tgt_ns        = ns;
        ctl.tgt_period_ns = per;
        ctl.tgt_ld        = 1'b1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        inc          = 32'd0;
        time_ptp_sec = 48'd5;
        time_ptp_ns  = 32'd999999950;
        pps_width    = 16'd4;
        ctl.tgt_ld = 1'b0; ctl.tgt_cancel = 1'b0;
        ctl.tgt_sec = '0; ctl.tgt_ns = '0; ctl.tgt_period_ns = '0;
        repeat (3) clk_step();
        n_chk++; if (pps_out !== 1'b0) begin n_fail++; $display("FAIL reset_pps got=%b exp=0", pps_out); end
        n_chk++; if (evt_out !== 1'b0) begin n_fail++; $display("FAIL reset_evt got=%b exp=0", evt_out); end
        n_chk++; if (ctl.armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed got=%b exp=0", ctl.armed); end
        n_chk++; if (ctl.ld_err !== 1'b0) begin n_fail++; $display("FAIL reset_ld_err got=%b exp=0", ctl.ld_err); end
        n_chk++; if (ctl.missed !== 1'b0) begin n_fail++; $display("FAIL reset_missed got=%b exp=0", ctl.missed); end
        rst = 1'b0;
    endtask

    // 5.999999950 stepping 8 ns: sec=6 is driven after edge 7 -> high after edges 9..12.
    task automatic test_pps_basic();
        logic exp;
        inc = 32'd8;
        for (int n = 1; n <= 16; n++) begin
            clk_step();
            exp = (n >= 9 && n <= 12);
            n_chk++;
            if (pps_out !== exp) begin n_fail++; $display("FAIL pps_basic n=%0d got=%b exp=%b", n, pps_out, exp); end
        end
    endtask

    task automatic test_pps_width0_restart();
        logic exp;
        pps_width    = 16'd0;
        time_ptp_sec = 48'd7;
        for (int n = 1; n <= 4; n++) begin
            clk_step();
            exp = (n == 2);
            n_chk++;
            if (pps_out !== exp) begin n_fail++; $display("FAIL pps_width0 n=%0d got=%b exp=%b", n, pps_out, exp); end
        end
        // Second change two cycles later restarts the 4-cycle count.
        pps_width    = 16'd4;
        time_ptp_sec = 48'd8;
        for (int n = 1; n <= 9; n++) begin
            clk_step();
            exp = (n >= 2 && n <= 7);
            n_chk++;
            if (pps_out !== exp) begin n_fail++; $display("FAIL pps_restart n=%0d got=%b exp=%b", n, pps_out, exp); end
            if (n == 2) time_ptp_sec = 48'd9;
        end
    endtask

    // Target 10.000000500; 504 is driven after edge 3 -> event after edge 5.
    task automatic test_oneshot();
        logic exp_e, exp_a;
        time_ptp_sec = 48'd10;
        time_ptp_ns  = 32'd480;
        drive_ld(48'd10, 32'd500, 32'd0);
        for (int n = 1; n <= 7; n++) begin
            clk_step();
            ctl.tgt_ld = 1'b0;
            exp_e = (n == 5);
            exp_a = (n <= 4);
            n_chk++;
            if (evt_out !== exp_e) begin n_fail++; $display("FAIL oneshot_evt n=%0d got=%b exp=%b", n, evt_out, exp_e); end
            n_chk++;
            if (ctl.armed !== exp_a) begin n_fail++; $display("FAIL oneshot_armed n=%0d got=%b exp=%b", n, ctl.armed, exp_a); end
        end
    endtask

    // Events when registered time passes 3.999999000, 4.000001000, 4.000003000.
    task automatic test_periodic();
        logic exp;
        time_ptp_sec = 48'd3;
        time_ptp_ns  = 32'd999998980;
        drive_ld(48'd3, 32'd999999000, 32'd2000);
        for (int n = 1; n <= 520; n++) begin
            clk_step();
            ctl.tgt_ld = 1'b0;
            exp = (n == 5) || (n == 255) || (n == 505);
            n_chk++;
            if (evt_out !== exp) begin n_fail++; $display("FAIL periodic_evt n=%0d got=%b exp=%b", n, evt_out, exp); end
        end
        n_chk++; if (ctl.missed !== 1'b0) begin n_fail++; $display("FAIL periodic_missed got=%b exp=0", ctl.missed); end
        n_chk++; if (ctl.armed !== 1'b1) begin n_fail++; $display("FAIL periodic_armed got=%b exp=1", ctl.armed); end
    endtask

    // Period 8 at 8 ns/clk, then +1 s jump: target stays due, one event per ADV.
    task automatic test_missed();
        logic exp;
        time_ptp_sec = 48'd20;
        time_ptp_ns  = 32'd0;
        drive_ld(48'd20, 32'd40, 32'd8);
        for (int n = 1; n <= 20; n++) begin
            clk_step();
            ctl.tgt_ld = 1'b0;
            exp = (n >= 7) && (n % 2 == 1);
            n_chk++;
            if (evt_out !== exp) begin n_fail++; $display("FAIL missed_evt n=%0d got=%b exp=%b", n, evt_out, exp); end
            if (n == 12) time_ptp_sec = 48'd21;
        end
        n_chk++; if (ctl.missed !== 1'b1) begin n_fail++; $display("FAIL missed_set got=%b exp=1", ctl.missed); end
        drive_ld(48'd100, 32'd0, 32'd0);
        clk_step();
        ctl.tgt_ld = 1'b0;
        n_chk++; if (ctl.missed !== 1'b0) begin n_fail++; $display("FAIL missed_clear got=%b exp=0", ctl.missed); end
        n_chk++; if (ctl.armed !== 1'b1) begin n_fail++; $display("FAIL missed_rearm got=%b exp=1", ctl.armed); end
    endtask

    task automatic test_ld_err_cancel();
        // Out-of-range ns while armed.
        drive_ld(48'd100, 32'd1000000000, 32'd0);
        clk_step();
        ctl.tgt_ld = 1'b0;
        n_chk++; if (ctl.ld_err !== 1'b1) begin n_fail++; $display("FAIL lderr_ns got=%b exp=1", ctl.ld_err); end
        n_chk++; if (ctl.armed !== 1'b1) begin n_fail++; $display("FAIL lderr_ns_armed got=%b exp=1", ctl.armed); end
        clk_step();
        n_chk++; if (ctl.ld_err !== 1'b0) begin n_fail++; $display("FAIL lderr_one_cycle got=%b exp=0", ctl.ld_err); end
        // Out-of-range period.
        drive_ld(48'd100, 32'd0, 32'd1000000000);
        clk_step();
        ctl.tgt_ld = 1'b0;
        n_chk++; if (ctl.ld_err !== 1'b1) begin n_fail++; $display("FAIL lderr_per got=%b exp=1", ctl.ld_err); end
        // Valid load together with cancel: cancel wins.
        drive_ld(48'd100, 32'd0, 32'd0);
        ctl.tgt_cancel = 1'b1;
        clk_step();
        ctl.tgt_ld = 1'b0; ctl.tgt_cancel = 1'b0;
        n_chk++; if (ctl.armed !== 1'b0) begin n_fail++; $display("FAIL ld_cancel_armed got=%b exp=0", ctl.armed); end
        n_chk++; if (ctl.ld_err !== 1'b0) begin n_fail++; $display("FAIL ld_cancel_lderr got=%b exp=0", ctl.ld_err); end
        // Invalid load together with cancel: no error.
        drive_ld(48'd100, 32'd1000000000, 32'd0);
        ctl.tgt_cancel = 1'b1;
        clk_step();
        ctl.tgt_ld = 1'b0; ctl.tgt_cancel = 1'b0;
        n_chk++; if (ctl.ld_err !== 1'b0) begin n_fail++; $display("FAIL bad_ld_cancel_lderr got=%b exp=0", ctl.ld_err); end
        // Invalid load in IDLE.
        drive_ld(48'd100, 32'd1000000000, 32'd0);
        clk_step();
        ctl.tgt_ld = 1'b0;
        n_chk++; if (ctl.ld_err !== 1'b1) begin n_fail++; $display("FAIL lderr_idle got=%b exp=1", ctl.ld_err); end
        n_chk++; if (ctl.armed !== 1'b0) begin n_fail++; $display("FAIL lderr_idle_armed got=%b exp=0", ctl.armed); end
    endtask

    task automatic test_mid_reset();
        pps_width    = 16'd4;
        time_ptp_sec = 48'd50;
        drive_ld(48'd100, 32'd0, 32'd0);
        clk_step();
        ctl.tgt_ld = 1'b0;
        clk_step();
        n_chk++; if (pps_out !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_pps got=%b exp=1", pps_out); end
        n_chk++; if (ctl.armed !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_armed got=%b exp=1", ctl.armed); end
        rst = 1'b1;
        clk_step();
        n_chk++; if (pps_out !== 1'b0) begin n_fail++; $display("FAIL midrst_pps got=%b exp=0", pps_out); end
        n_chk++; if (ctl.armed !== 1'b0) begin n_fail++; $display("FAIL midrst_armed got=%b exp=0", ctl.armed); end
        rst = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            clk_step();
            n_chk++;
            if (pps_out !== 1'b0) begin n_fail++; $display("FAIL midrst_exit n=%0d got=%b exp=0", n, pps_out); end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_pps_basic();
        test_pps_width0_restart();
        test_oneshot();
        test_periodic();
        test_missed();
        test_ld_err_cancel();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
